ram_bank: RTL and testbench
===========================

RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of words (power of two, >=2).
REQ-003 The block SHALL have derived parameter ADDR_W, default $clog2(DEPTH), meaning address width; it is not overridden by instantiators.
REQ-004 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port in  input  WIDTH  write data.
REQ-007 The block SHALL have port addr  input  ADDR_W  shared read/write address.
REQ-008 The block SHALL have port load  input  1  write enable; writes in to mem[addr] at the clock edge.
REQ-009 The block SHALL have port clr  input  1  one-cycle request to start a clear sweep.
REQ-010 The block SHALL have port out  output  WIDTH  combinational read of mem[addr].
REQ-011 The block SHALL have port busy  output  1  high while a clear sweep is in progress.

Function
REQ-012 out SHALL equal mem[addr] combinationally (zero-cycle latency from addr).
REQ-013 When load=1, busy=0 and clr=0 at a rising edge, mem[addr] SHALL take in; all other words SHALL hold.
REQ-014 Read-during-write: out SHALL show the old word until the edge, then the new word.
REQ-015 The FSM SHALL have two states: IDLE and SWEEP.
REQ-016 IDLE->SWEEP SHALL occur on an edge with clr=1; the sweep counter SHALL load 0.
REQ-017 In SWEEP, each edge SHALL zero mem[counter] and increment counter.
REQ-018 SWEEP->IDLE SHALL occur on the edge that zeroes word DEPTH-1; sweep length is exactly DEPTH cycles.
REQ-019 busy SHALL be 1 exactly while the state is SWEEP (registered, no combinational path from clr).
REQ-020 load SHALL be ignored while busy=1; dropped writes are not queued.
REQ-021 When clr=1 and load=1 coincide in IDLE, clr SHALL win and the write SHALL be dropped.
REQ-022 clr asserted while busy=1 SHALL be ignored; the sweep SHALL neither restart nor extend.
REQ-023 The counter SHALL be ADDR_W bits and SHALL NOT wrap beyond DEPTH-1 in SWEEP.
REQ-024 out SHALL remain a valid read of mem[addr] during SWEEP, showing zeroed words as they clear.

Reset
REQ-025 With rst_n=0, all DEPTH words SHALL go to 0 asynchronously.
REQ-026 With rst_n=0, the state SHALL go to IDLE, the counter to 0 and busy to 0.
REQ-027 With rst_n=0, out SHALL read 0 for any addr.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep, clear all words and return to IDLE.
REQ-029 The first edge after rst_n rises SHALL obey REQ-013/016 normally.

Structure
REQ-030 The IDLE/SWEEP state encoding constants SHALL live in the shared gates package/include.
REQ-031 Each storage word SHALL be an instance of one sub-module, word_reg (WIDTH-bit register with load enable, synchronous clear input, async active-low reset).
REQ-032 The write decode SHALL be a parametrised demux of load over addr.
REQ-033 The read path SHALL be a parametrised DEPTH:1 mux of the word outputs.

Verification
REQ-034 Write then read: load=1, addr=3, in=16'hBEEF, one edge -> out=16'hBEEF at addr=3 and 0 at every other address.
REQ-035 Write/hold: load=0, in=16'h1234, addr=3 over 5 edges -> mem[3] stays 16'hBEEF.
REQ-036 Sweep: fill all 8 words with 16'hFFFF, pulse clr one cycle -> busy=1 for exactly 8 cycles; mem[k]=0 after edge k+1; busy=0 afterwards.
REQ-037 Collision and busy lockout: clr=1 and load=1 (addr=2, in=16'h00AA) together -> mem[2]=0 after the sweep; load during busy -> no change; clr during busy -> sweep still ends after 8 cycles.
REQ-038 Reset mid-sweep: rst_n=0 at sweep cycle 4 -> busy=0 immediately and all words 0; after release, write addr=7 in=16'h0001 -> out=16'h0001.
REQ-039 Parameter sweep: the bench SHALL rerun REQ-034 and REQ-036 with WIDTH=1, DEPTH=2 and with WIDTH=32, DEPTH=16.

Source files
------------

// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared IDLE/SWEEP state encoding for ram_bank
package ram_bank_pkg;
  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_e;
endpackage

// File: rtl/word_reg.sv
// word_reg: WIDTH-bit storage word; ports clk, rst_n (async low), load_i, clear_i (sync, wins over load), d_i, q_o
module word_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] q_q, q_d;
  always_comb q_d = clear_i ? '0 : load_i ? d_i : q_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/ram_bank.sv
// ram_bank: DEPTH x WIDTH bank; comb read out=mem[addr], write in on load, clr starts a DEPTH-cycle zeroing sweep flagged by busy; async low rst_n
module ram_bank
  import ram_bank_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en, last;
  logic [DEPTH-1:0]  ld_vec, clr_vec;
  logic [WIDTH-1:0]  word_q [DEPTH];
  assign wr_en = state_q == IDLE && load && !clr;
  assign last  = cnt_q == ADDR_W'(DEPTH - 1);
  always_comb begin
    state_d = state_q == IDLE ? (clr ? SWEEP : IDLE) : (last ? IDLE : SWEEP);
    cnt_d   = state_q == SWEEP ? ADDR_W'(cnt_q + 1'b1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign ld_vec[i]  = wr_en && addr == ADDR_W'(i);
    assign clr_vec[i] = state_q == SWEEP && cnt_q == ADDR_W'(i);
    word_reg #(.WIDTH(WIDTH)) u_word (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (ld_vec[i]),
      .clear_i(clr_vec[i]),
      .d_i    (in),
      .q_o    (word_q[i])
    );
  end
  assign out  = word_q[addr];
  assign busy = state_q == SWEEP;
endmodule

// File: tb/tb_ram_bank.sv
// tb_ram_bank: drives three ram_bank configurations in lockstep against a behavioural model and scoreboard
module tb_ram_bank;
  logic        clk = 1'b0;
  logic        rst_n, load, clr;
  logic [31:0] in;
  logic [3:0]  addr;
  logic [15:0] out_a;
  logic [0:0]  out_b;
  logic [31:0] out_c;
  logic        busy_a, busy_b, busy_c;
  int          n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  ram_bank #(.WIDTH(16), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in[15:0]), .addr(addr[2:0]),
    .load(load), .clr(clr), .out(out_a), .busy(busy_a));
  ram_bank #(.WIDTH(1), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in[0:0]), .addr(addr[0:0]),
    .load(load), .clr(clr), .out(out_b), .busy(busy_b));
  ram_bank #(.WIDTH(32), .DEPTH(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(in), .addr(addr),
    .load(load), .clr(clr), .out(out_c), .busy(busy_c));

  localparam int          DEP [3] = '{8, 2, 16};
  localparam logic [31:0] MSK [3] = '{32'h0000_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};

  logic [31:0] mm [3][16];
  bit          mb [3];
  int          mc [3];

  typedef struct {logic [31:0] o; logic b;} exp_t;
  exp_t sb [$];

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mb[i] = 1'b0;
      mc[i] = 0;
      for (int j = 0; j < 16; j++) mm[i][j] = '0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 3; i++) begin
      int a;
      a = int'(addr) % DEP[i];
      if (mb[i]) begin
        mm[i][mc[i]] = '0;
        if (mc[i] == DEP[i] - 1) begin
          mb[i] = 1'b0;
          mc[i] = 0;
        end else mc[i]++;
      end else if (clr) begin
        mb[i] = 1'b1;
        mc[i] = 0;
      end else if (load) mm[i][a] = in & MSK[i];
    end
  endfunction

  function automatic void push_expect();
    for (int i = 0; i < 3; i++) sb.push_back('{mm[i][int'(addr) % DEP[i]], mb[i]});
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, i, obs, exp);
    end
  endtask

  task automatic check_dut(input string tag);
    for (int i = 0; i < 3; i++) begin
      exp_t        e;
      logic [31:0] o;
      logic        b;
      e = sb.pop_front();
      o = i == 0 ? {16'b0, out_a} : i == 1 ? {31'b0, out_b} : out_c;
      b = i == 0 ? busy_a : i == 1 ? busy_b : busy_c;
      chk({tag, "_out"}, i, o, e.o);
      chk({tag, "_busy"}, i, {31'b0, b}, {31'b0, e.b});
    end
  endtask

  task automatic cyc(input string tag);
    model_edge();
    push_expect();
    @(posedge clk);
    #1;
    check_dut(tag);
  endtask

  task automatic read_check(input string tag);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      addr = 4'(k);
      #1;
      push_expect();
      check_dut(tag);
    end
  endtask

  task automatic fill_ones();
    load = 1'b1;
    in   = '1;
    for (int k = 0; k < 16; k++) begin
      addr = 4'(k);
      cyc("fill");
    end
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    clr   = 1'b0;
    in    = '0;
    addr  = '0;
    model_reset();
    read_check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 4'd3;
    in    = 32'h0000_BEEF;
    load  = 1'b1;
    cyc("write");
    load = 1'b0;
    chk("beef_a", 0, {16'b0, out_a}, 32'h0000_BEEF);
    chk("beef_c", 2, out_c, 32'h0000_BEEF);
    read_check("write_read");
    @(negedge clk);
    addr = 4'd3;
    in   = 32'h0000_1234;
    for (int k = 0; k < 5; k++) cyc("hold");
    chk("hold_a", 0, {16'b0, out_a}, 32'h0000_BEEF);
    fill_ones();
    read_check("filled");
    @(negedge clk);
    clr = 1'b1;
    cyc("clr");
    clr = 1'b0;
    for (int k = 0; k < 18; k++) begin
      addr = 4'(k);
      cyc("sweep");
    end
    chk("sweep_idle_a", 0, {31'b0, busy_a}, 32'd0);
    read_check("swept");
    @(negedge clk);
    fill_ones();
    addr = 4'd2;
    in   = 32'h0000_00AA;
    load = 1'b1;
    clr  = 1'b1;
    cyc("collide");
    for (int k = 0; k < 18; k++) begin
      addr = 4'(k);
      in   = 32'h0000_5555;
      load = k < 4;
      clr  = k == 3 || k == 6;
      cyc("lockout");
    end
    load = 1'b0;
    clr  = 1'b0;
    addr = 4'd2;
    #1;
    chk("collide_a", 0, {16'b0, out_a}, 32'd0);
    read_check("lockout_mem");
    @(negedge clk);
    fill_ones();
    clr = 1'b1;
    cyc("clr2");
    clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      addr = 4'(k);
      cyc("sweep2");
    end
    rst_n = 1'b0;
    addr  = 4'd6;
    #1;
    model_reset();
    push_expect();
    check_dut("rst_async");
    read_check("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 4'd7;
    in    = 32'h0000_0001;
    load  = 1'b1;
    cyc("post_rst");
    load = 1'b0;
    chk("post_rst_a", 0, {16'b0, out_a}, 32'h0000_0001);
    read_check("post_rst_mem");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
